// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_bank_pkg: shared command layout, FSM states and LOCK bit helper for spi_reg_bank
package spi_reg_bank_pkg;
  localparam int CMD_W = 8;
  localparam int CMD_WR_BIT = 7;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
  function automatic int lock_bit(input int reg_w);
    return reg_w - 1;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser with rise/fall pulse detect on the synced level
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], d_i};
  // Resets low so a cs_n already low at reset release never looks like a falling edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave register bank with burst, wrap, RO status; SPI_REG_BANK_LOCK_EN adds reg0 LOCK
module spi_reg_bank import spi_reg_bank_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int REG_W = 8,
  parameter int NUM_RO = 1,
  parameter logic [REG_W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic [(2**ADDR_W-NUM_RO)*REG_W-1:0] regs_o,
  input  logic [(NUM_RO > 0 ? NUM_RO : 1)*REG_W-1:0] status_i,
  output logic [2**ADDR_W-1:0] wr_stb_o,
  output logic busy_o
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_RW = NUM_REGS - NUM_RO;
  localparam int CNT_W = 5;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] sr_q, sr_d, tx_q, tx_d, word;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic [1:0] mosi_q, mosi_d;
  logic wr_q, wr_d, fresh_q, fresh_d;
  logic [NUM_REGS-1:0] stb_q, stb_d;
  logic [REG_W-1:0] regs_q [NUM_RW];
  logic [REG_W-1:0] regs_d [NUM_RW];
  logic [REG_W-1:0] bank [NUM_REGS];
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cmd_end, word_end, commit, locked;
  spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d_i(spi_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge u_cs (.clk(clk), .rst_n(rst_n), .d_i(spi_cs_n), .rise_o(cs_rise), .fall_o(cs_fall));
  assign word = {sr_q[REG_W-2:0], mosi_q[1]};
  assign cmd_end = state_q == CMD && sclk_rise && !cs_rise && cnt_q == CNT_W'(CMD_W - 1);
  assign word_end = state_q == DATA && sclk_rise && !cs_rise && cnt_q == CNT_W'(REG_W - 1);
`ifdef SPI_REG_BANK_LOCK_EN
  assign locked = addr_q != '0 && regs_q[0][lock_bit(REG_W)];
`else
  assign locked = 1'b0;
`endif
  assign commit = word_end && wr_q && int'(addr_q) < NUM_RW && !locked;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = cs_rise ? IDLE : (state_q == IDLE && cs_fall) ? CMD : cmd_end ? DATA : state_q;
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_RW; k++) if (commit && int'(addr_q) == k) regs_d[k] = word;
  end
  // Reads see regs_d so a load coinciding with a commit returns the new value
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
    if (g < NUM_RW) begin : g_rw
      assign bank[g] = regs_d[g];
      assign regs_o[g*REG_W +: REG_W] = regs_q[g];
    end else begin : g_ro
      assign bank[g] = status_i[(g - NUM_RW)*REG_W +: REG_W];
    end
  end
  always_comb begin
    mosi_d = {mosi_q[0], spi_mosi};
    sr_d = (state_q != IDLE && sclk_rise) ? word : sr_q;
    cnt_d = (state_d != state_q || state_q == IDLE || word_end) ? '0 : sclk_rise ? cnt_q + 1'b1 : cnt_q;
    addr_d = cmd_end ? word[ADDR_W-1:0] : word_end ? addr_q + 1'b1 : addr_q;
    wr_d = cmd_end ? word[CMD_WR_BIT] : wr_q;
    rd_addr = cmd_end ? word[ADDR_W-1:0] : addr_q + 1'b1;
    // The fall right after a load must not shift, or the MSB is lost before the master samples it
    tx_d = state_d != DATA ? '0 : (cmd_end || word_end) ? bank[rd_addr] : (sclk_fall && !fresh_q) ? tx_q << 1 : tx_q;
    fresh_d = cmd_end || word_end || (fresh_q && !sclk_fall);
    stb_d = commit ? NUM_REGS'(1) << addr_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q <= '0;
      tx_q <= '0;
      addr_q <= '0;
      mosi_q <= '0;
      wr_q <= 1'b0;
      fresh_q <= 1'b0;
      stb_q <= '0;
      regs_q <= '{default: RST_VAL};
    end else begin
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      tx_q <= tx_d;
      addr_q <= addr_d;
      mosi_q <= mosi_d;
      wr_q <= wr_d;
      fresh_q <= fresh_d;
      stb_q <= stb_d;
      regs_q <= regs_d;
    end
  always_comb begin
    spi_miso = tx_q[REG_W-1];
    spi_miso_oe = state_q != IDLE;
    busy_o = state_q != IDLE;
  end
  assign wr_stb_o = stb_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized SPI master with scoreboard against a word-level register model
module tb_spi_reg_bank;
  localparam int HP = 50;
`ifdef SPI_REG_BANK_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  typedef struct {logic [7:0] mask; int idx; logic [7:0] val;} stb_t;
  logic clk = 0, rst_n = 0, spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0;
  logic spi_miso, spi_miso_oe, busy_o;
  logic [55:0] regs_o;
  logic [7:0] status_i = 8'h00;
  logic [7:0] wr_stb_o;
  int vectors = 0, errors = 0;
  logic [7:0] model [8];
  logic [7:0] dbuf [16];
  stb_t exp_stb [$];
  logic [7:0] exp_rd [$], got_rd [$];
  always #5 clk = ~clk;
  spi_reg_bank #(.ADDR_W(3), .REG_W(8), .NUM_RO(1), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .regs_o(regs_o), .status_i(status_i),
    .wr_stb_o(wr_stb_o), .busy_o(busy_o));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [55:0] model_flat();
    logic [55:0] r;
    for (int k = 0; k < 7; k++) r[k*8 +: 8] = model[k];
    return r;
  endfunction
  task automatic model_frame(input logic [7:0] cmd, input int words);
    for (int i = 0; i < words; i++) begin
      int ad;
      ad = (int'(cmd[2:0]) + i) % 8;
      exp_rd.push_back(ad < 7 ? model[ad] : status_i);
      if (cmd[7] && ad < 7 && !(LOCK && ad != 0 && model[0][7])) begin
        model[ad] = dbuf[i];
        exp_stb.push_back('{8'(1) << ad, ad, dbuf[i]});
      end
    end
  endtask
  task automatic spi_bit(input logic b, output logic s);
    spi_mosi = b;
    #HP;
    s = spi_miso;
    spi_sclk = 1;
    #HP;
    spi_sclk = 0;
  endtask
  task automatic xfer(input logic [7:0] cmd, input int n, input int abort_bits);
    int nbits;
    logic s, cm;
    logic [7:0] g;
    nbits = abort_bits < 0 ? n * 8 : abort_bits;
    model_frame(cmd, nbits / 8);
    cm = 0;
    g = 0;
    spi_cs_n = 0;
    for (int b = 7; b >= 0; b--) begin
      spi_bit(cmd[b], s);
      cm |= s;
    end
    check("cmd_miso", cm, 0);
    check("busy_oe", {busy_o, spi_miso_oe}, 2'b11);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(dbuf[i/8][7 - i%8], s);
      g = {g[6:0], s};
      if (i % 8 == 7) got_rd.push_back(g);
    end
    #HP;
    spi_cs_n = 1;
    #(4*HP);
    check("idle_after", {busy_o, spi_miso_oe, spi_miso}, 3'b000);
    check("regs", regs_o, model_flat());
  endtask
  always @(negedge clk) begin
    stb_t e;
    if (rst_n && wr_stb_o !== 8'h00) begin
      if (exp_stb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_stb: got %h expected none", wr_stb_o);
      end else begin
        e = exp_stb.pop_front();
        check("stb_mask", wr_stb_o, e.mask);
        check("stb_reg", regs_o[e.idx*8 +: 8], e.val);
      end
    end
    if (got_rd.size() != 0) begin
      if (exp_rd.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", got_rd.pop_front());
      end else check("miso_word", got_rd.pop_front(), exp_rd.pop_front());
    end
  end
  initial begin
    logic s;
    for (int k = 0; k < 8; k++) model[k] = 8'h00;
    #23;
    check("rst_regs", regs_o, 56'h0);
    check("rst_outs", {spi_miso, spi_miso_oe, busy_o}, 3'b000);
    check("rst_stb", wr_stb_o, 8'h00);
    rst_n = 1;
    #100;
    dbuf[0] = 8'h5A;
    xfer(8'h82, 1, -1);
    dbuf[0] = 8'h00;
    xfer(8'h02, 1, -1);
    status_i = 8'hC3;
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
    xfer(8'h86, 3, -1);
    dbuf[0] = 8'h00; dbuf[1] = 8'h00;
    xfer(8'h07, 2, -1);
    dbuf[0] = 8'hAA;
    xfer(8'h81, 1, 4);
    dbuf[0] = 8'h77;
    xfer(8'h81, 1, -1);
    spi_cs_n = 0;
    for (int b = 7; b >= 4; b--) spi_bit(b == 7, s);
    rst_n = 0;
    #33;
    check("midrst_regs", regs_o, 56'h0);
    rst_n = 1;
    for (int k = 0; k < 8; k++) model[k] = 8'h00;
    for (int b = 3; b >= 0; b--) spi_bit(b == 0, s);
    for (int b = 0; b < 8; b++) spi_bit(1'b1, s);
    check("midrst_busy", busy_o, 1'b0);
    #HP;
    spi_cs_n = 1;
    #(4*HP);
    check("midrst_after", regs_o, model_flat());
    dbuf[0] = 8'h80;
    xfer(8'h80, 1, -1);
    dbuf[0] = 8'hFF;
    xfer(8'h83, 1, -1);
    dbuf[0] = 8'h00;
    xfer(8'h80, 1, -1);
    dbuf[0] = 8'hFF;
    xfer(8'h83, 1, -1);
    for (int t = 0; t < 30; t++) begin
      int n, ab;
      status_i = 8'($urandom);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n * 8 - 1) : -1;
      xfer(8'($urandom), n, ab);
    end
    #200;
    check("stb_pending", exp_stb.size(), 0);
    check("rd_pending", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI-slave register bank: a self-contained SPI mode-0 frame engine plus a generic read/write register file with read-only status slots.
- Supports multi-word burst with address auto-increment and wrap, plus per-register write strobes.
- Sits directly behind the chip pins (cs_n/sclk/mosi/miso) and feeds configuration registers to datapath blocks such as the RSA unit.

Parameters:
- ADDR_W, 3, register address width; 1..7. Bank holds 2^ADDR_W registers.
- REG_W, 8, register width in bits; 8..32.
- NUM_RO, 1, number of read-only registers at the top addresses; 0..2^ADDR_W-1. NUM_RW = 2^ADDR_W - NUM_RO.
- RST_VAL, 0, reset value of every RW register (REG_W bits).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- spi_cs_n, in, 1, chip select, active low, asynchronous to clk.
- spi_sclk, in, 1, SPI clock, mode 0, asynchronous; frequency must be ≤ clk/6.
- spi_mosi, in, 1, serial data in, MSB first.
- spi_miso, out, 1, serial data out, MSB first.
- spi_miso_oe, out, 1, high while the frame is active (cs_n synced low).
- regs_o, out, NUM_RW*REG_W, RW register contents; reg k occupies [k*REG_W +: REG_W].
- status_i, in, NUM_RO*REG_W, read-only sources; slice j is returned at address NUM_RW+j.
- wr_stb_o, out, 2^ADDR_W, one-clk pulse per register actually written.
- busy_o, out, 1, frame in progress.

Behaviour:
- Reset and clocking: clk is the clock; rst_n is an asynchronous, active-low reset.
- Reset values: regs = RST_VAL; spi_miso = 0; spi_miso_oe = 0; wr_stb_o = 0; busy_o = 0; FSM in IDLE.
- Synchronisation: cs_n, sclk and mosi each pass through a 2-FF synchroniser. Edge detect on synced sclk produces rise and fall pulses. All logic runs on clk.
- FSM IDLE -> CMD on synced cs_n falling edge. If cs_n is already low at reset release, the frame is ignored until cs_n rises and then falls again.
- CMD: shift 8 bits on sclk rise.
  - bit7 = 1 selects write, 0 selects read.
  - bits[ADDR_W-1:0] = start address; the remaining bits are ignored.
  - After the 8th rise -> DATA.
- DATA:
  - On entry, and on every REG_W-th rise thereafter, load the tx shifter with the value at the current address (RW reg or status_i slice). The MSB appears on spi_miso within 1 clk.
  - The shifter advances on each sclk fall.
  - rx shifts in on each rise.
  - On the REG_W-th rise of a word in a write frame, the target register captures the word.
  - Address then increments modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- MISO during CMD is 0. In DATA, MISO carries current contents in both read and write frames (full duplex; old value shifted out).
- Write commit:
  - Applies only if the address < NUM_RW; writes to RO addresses are discarded with no strobe.
  - wr_stb_o[addr] pulses high exactly 1 clk, on the clk after the commit; regs_o shows the new value on the same clk.
  - A read-load in the same clk as a commit to the same address returns the new value.
- Abort: synced cs_n rise in any state -> IDLE next clk. A partial word (< REG_W bits) is discarded: no write, no strobe. spi_miso_oe and busy_o drop in the same clk.
- Excess sclk edges while in IDLE are ignored.
- Reset mid-frame: immediate return to reset values; the resumed frame is ignored (see CMD rule).

Optional Feature:
- Macro SPI_REG_BANK_LOCK_EN.
  - Defined: bit REG_W-1 of register 0 is a LOCK bit. While it is 1, writes to addresses 1..NUM_RW-1 are discarded with no strobe. Register 0 stays writable, so LOCK can be cleared.
  - Undefined: register 0 is an ordinary RW register; there is no lock logic.

Decomposition:
- Package spi_reg_bank_pkg holds:
  - CMD_W = 8;
  - CMD_WR_BIT = 7;
  - FSM state enum (IDLE, CMD, DATA);
  - LOCK_BIT offset helper.
- Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse detect. It is instanced for sclk and cs_n; mosi uses sync only.

Test Plan:
All scenarios use ADDR_W=3, REG_W=8, NUM_RO=1, RST_VAL=0.
- Reset: assert rst_n low -> regs_o = 0, spi_miso = 0, oe = 0, wr_stb_o = 0x00.
- Write then read: frame 0x82, 0x5A -> regs_o[2] = 0x5A, wr_stb_o = 0x04 for exactly 1 clk. Frame 0x02, 0x00 -> MISO returns 0x5A.
- Burst with wrap: frame 0x86, 0x11, 0x22, 0x33 -> reg6 = 0x11; addr 7 (RO) unchanged; reg0 = 0x33. Strobes occur on bits 6 and 0 only.
- RO read: status_i = 0xC3, frame 0x07, 2 words -> MISO returns 0xC3 then reg0 contents.
- Abort: frame 0x81 with cs_n raised after 4 data bits -> reg1 unchanged, no strobe, FSM in IDLE. The next full frame works normally.
- Lock, macro on: write reg0 = 0x80, then frame 0x83, 0xFF -> reg3 stays 0, no strobe. Clear reg0 to 0x00, retry -> reg3 = 0xFF. With the macro off, the first attempt writes 0xFF.
